// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared types and constants for the RTC multiplexed-bus sequencer.
package rtc_bus_pkg;

  // Transaction sequence; every non-IDLE state reports busy.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ADDR_SETUP = 3'd1,
    ST_ADDR_PULSE = 3'd2,
    ST_GAP        = 3'd3,
    ST_DATA_PULSE = 3'd4,
    ST_DATA_HOLD  = 3'd5,
    ST_DONE       = 3'd6
  } rtc_state_e;

  // Width of the phase down-counter; phase lengths are limited to 1..63.
  localparam int TMR_W = 6;

  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_PULSE = 8;
  localparam int DEF_T_GAP   = 4;
  localparam int DEF_T_HOLD  = 2;

  // Turns a requested phase length into a legal timer duration (0 -> 1, >63 -> 63).
  function automatic logic [TMR_W-1:0] clamp1(input int v);
    if (v < 1) begin
      return TMR_W'(1);
    end else if (v > 63) begin
      return TMR_W'(63);
    end else begin
      return TMR_W'(v);
    end
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// Request and pin-side signals of the RTC bus sequencer.
//
// Handshake: start is a request that is only looked at while busy is low;
// wr_rd/addr/wdata must be valid in the same cycle as start. There is no
// separate ready: busy high means a request will be dropped, not queued.
// done pulses for exactly one cycle when a transaction completes, and rdata
// is valid from that cycle until the next read completes.
interface rtc_bus_ctrl_if;
  import rtc_bus_pkg::*;

  logic       start;
  logic       wr_rd;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  rtc_state_e dbg_state;

  // Requester / pad side.
  modport master (
    output start, wr_rd, addr, wdata, ad_in,
    input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, busy, done, rdata, dbg_state
  );

  // Sequencer side.
  modport slave (
    input  start, wr_rd, addr, wdata, ad_in,
    output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, busy, done, rdata, dbg_state
  );

endinterface

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Down-counting phase timer: loaded with (dur-1) on phase entry, expired at 0.
module rtc_phase_timer
  import rtc_bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] dur,
  output logic             expired
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Next count: reload on phase entry, otherwise count down and park at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = dur - TMR_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed address/data bus sequencer: one start runs a complete
// address phase, gap, data phase and hold with programmable lengths.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_GAP   = DEF_T_GAP,
  parameter int T_HOLD  = DEF_T_HOLD
) (
  input logic           clk,
  input logic           reset,
  rtc_bus_ctrl_if.slave bus
);

  localparam logic [TMR_W-1:0] D_SETUP = clamp1(T_SETUP);
  localparam logic [TMR_W-1:0] D_PULSE = clamp1(T_PULSE);
  localparam logic [TMR_W-1:0] D_GAP   = clamp1(T_GAP);
  localparam logic [TMR_W-1:0] D_HOLD  = clamp1(T_HOLD);

  rtc_state_e       state_q;
  rtc_state_e       state_d;
  logic             wr_q;
  logic [7:0]       addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rdata_q;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_dur;
  logic             tmr_expired;

  logic             cs_n_dec;
  logic             rd_n_dec;
  logic             wr_n_dec;
  logic             a_d_dec;
  logic             ad_oe_dec;
  logic [7:0]       ad_out_dec;
  logic             done_dec;

  rtc_phase_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .dur     (tmr_dur),
    .expired (tmr_expired)
  );

  // Next state plus timer reload; every change of state reloads the timer.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dur  = TMR_W'(1);
    unique case (state_q)
      ST_IDLE:       if (bus.start)   state_d = ST_ADDR_SETUP;
      ST_ADDR_SETUP: if (tmr_expired) state_d = ST_ADDR_PULSE;
      ST_ADDR_PULSE: if (tmr_expired) state_d = ST_GAP;
      ST_GAP:        if (tmr_expired) state_d = ST_DATA_PULSE;
      ST_DATA_PULSE: if (tmr_expired) state_d = ST_DATA_HOLD;
      ST_DATA_HOLD:  if (tmr_expired) state_d = ST_DONE;
      ST_DONE:                        state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
    tmr_load = (state_d != state_q);
    unique case (state_d)
      ST_ADDR_SETUP: tmr_dur = D_SETUP;
      ST_ADDR_PULSE: tmr_dur = D_PULSE;
      ST_GAP:        tmr_dur = D_GAP;
      ST_DATA_PULSE: tmr_dur = D_PULSE;
      ST_DATA_HOLD:  tmr_dur = D_HOLD;
      default:       tmr_dur = TMR_W'(1);
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture in IDLE, read data capture on the last data-strobe edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.start) begin
        wr_q    <= bus.wr_rd;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (state_q == ST_DATA_PULSE && tmr_expired && !wr_q) begin
        rdata_q <= bus.ad_in;
      end
    end
  end

  // Pin decode from registered state only, so no input reaches a pin.
  // The address strobe is always wr_n, for reads as well as writes.
  always_comb begin
    cs_n_dec   = 1'b1;
    rd_n_dec   = 1'b1;
    wr_n_dec   = 1'b1;
    a_d_dec    = 1'b1;
    ad_oe_dec  = 1'b0;
    ad_out_dec = wdata_q;
    done_dec   = 1'b0;
    unique case (state_q)
      ST_ADDR_SETUP: begin
        cs_n_dec   = 1'b0;
        a_d_dec    = 1'b0;
        ad_oe_dec  = 1'b1;
        ad_out_dec = addr_q;
      end
      ST_ADDR_PULSE: begin
        cs_n_dec   = 1'b0;
        wr_n_dec   = 1'b0;
        a_d_dec    = 1'b0;
        ad_oe_dec  = 1'b1;
        ad_out_dec = addr_q;
      end
      ST_GAP: begin
        ad_oe_dec = wr_q;
      end
      ST_DATA_PULSE: begin
        cs_n_dec  = 1'b0;
        wr_n_dec  = !wr_q;
        rd_n_dec  = wr_q;
        ad_oe_dec = wr_q;
      end
      ST_DATA_HOLD: begin
        ad_oe_dec = wr_q;
      end
      ST_DONE: begin
        done_dec = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.cs_n      = cs_n_dec;
  assign bus.rd_n      = rd_n_dec;
  assign bus.wr_n      = wr_n_dec;
  assign bus.a_d       = a_d_dec;
  assign bus.ad_oe     = ad_oe_dec;
  assign bus.ad_out    = ad_out_dec;
  assign bus.done      = done_dec;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rdata     = rdata_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: three parameterisations, a timeline reference
// model built from the phase lengths, and a done/rdata scoreboard.
module tb_rtc_bus_ctrl;

  localparam int PH_IDLE   = 0;
  localparam int PH_SETUP  = 1;
  localparam int PH_APULSE = 2;
  localparam int PH_GAP    = 3;
  localparam int PH_DPULSE = 4;
  localparam int PH_HOLD   = 5;
  localparam int PH_DONE   = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  rtc_bus_ctrl_if b0 ();
  rtc_bus_ctrl_if b1 ();
  rtc_bus_ctrl_if b2 ();

  rtc_bus_ctrl u_dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  rtc_bus_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_GAP(1), .T_HOLD(1))
    u_dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  rtc_bus_ctrl #(.T_SETUP(1), .T_PULSE(0), .T_GAP(1), .T_HOLD(1))
    u_dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

  // ---------------- reference model state ----------------
  int         ts[3];
  int         tp[3];
  int         tg[3];
  int         th[3];
  int         last_k[3];
  logic       cur_wr[3];
  logic [7:0] cur_addr[3];
  logic [7:0] cur_wdata[3];
  logic [7:0] cur_rval[3];
  logic [7:0] rdata_m[3];

  // Scoreboard entry: {dut id[1:0], done cycle[21:0], rdata[7:0]}.
  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic int clampi(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int n_of(input int id);
    return ts[id] + 2 * tp[id] + tg[id] + th[id];
  endfunction

  // Phase occupied t cycles after the start-sampling edge.
  function automatic int phase_of(input int id, input int t);
    int b;
    if (t < 0) return PH_IDLE;
    b = ts[id];
    if (t < b) return PH_SETUP;
    b = b + tp[id];
    if (t < b) return PH_APULSE;
    b = b + tg[id];
    if (t < b) return PH_GAP;
    b = b + tp[id];
    if (t < b) return PH_DPULSE;
    b = b + th[id];
    if (t < b) return PH_HOLD;
    if (t == b) return PH_DONE;
    return PH_IDLE;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int id, input logic s, input logic w,
                       input logic [7:0] a, input logic [7:0] wd);
    case (id)
      0: begin b0.start = s; b0.wr_rd = w; b0.addr = a; b0.wdata = wd; end
      1: begin b1.start = s; b1.wr_rd = w; b1.addr = a; b1.wdata = wd; end
      default: begin b2.start = s; b2.wr_rd = w; b2.addr = a; b2.wdata = wd; end
    endcase
  endtask

  // Presents start for exactly one edge; the model decides whether it is taken.
  task automatic do_start(input int id, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, input logic [7:0] rv);
    int          e;
    logic [21:0] dc;
    e = cyc + 1;
    drive(id, 1'b1, wr, a, wd);
    if (phase_of(id, e - 1 - last_k[id]) == PH_IDLE) begin
      last_k[id]    = e;
      cur_wr[id]    = wr;
      cur_addr[id]  = a;
      cur_wdata[id] = wd;
      cur_rval[id]  = rv;
      if (!wr) rdata_m[id] = rv;
      dc = 22'(e + n_of(id));
      exp_q.push_back({2'(id), dc, rdata_m[id]});
    end
    @(posedge clk);
    #1;
    drive(id, 1'b0, ~wr, ~a, ~wd);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      last_k[i]  = -1000;
      rdata_m[i] = 8'h00;
      cur_rval[i] = 8'h00;
      cur_wr[i]   = 1'b0;
    end
  endtask

  task automatic check_rst(input string nm, input logic [6:0] pins,
                           input logic [7:0] aout, input logic [7:0] rd);
    check({nm, "_pins"},   {25'd0, pins}, {25'd0, 7'b1111000});
    check({nm, "_adout"},  {24'd0, aout}, 32'h0);
    check({nm, "_rdata"},  {24'd0, rd},   32'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check_dut(input int id, input logic [6:0] pins,
                           input logic [7:0] aout, input logic [7:0] rdat);
    int          ph;
    logic [6:0]  ev;
    logic [31:0] ent;
    logic [7:0]  eo;
    ph = phase_of(id, cyc - last_k[id]);
    case (ph)
      PH_SETUP:  ev = 7'b0110110;
      PH_APULSE: ev = 7'b0100110;
      PH_GAP:    ev = {4'b1111, cur_wr[id], 2'b10};
      PH_DPULSE: ev = cur_wr[id] ? 7'b0101110 : 7'b0011010;
      PH_HOLD:   ev = {4'b1111, cur_wr[id], 2'b10};
      PH_DONE:   ev = 7'b1111011;
      default:   ev = 7'b1111000;
    endcase
    check($sformatf("pins_dut%0d_ph%0d", id, ph), {25'd0, pins}, {25'd0, ev});
    if (ev[2]) begin
      eo = (ph == PH_SETUP || ph == PH_APULSE) ? cur_addr[id] : cur_wdata[id];
      check($sformatf("adout_dut%0d_ph%0d", id, ph), {24'd0, aout}, {24'd0, eo});
    end
    if (pins[0] === 1'b1) begin
      if (exp_q.size() == 0) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL unexpected_done dut%0d: got done=1 expected none at cycle %0d", id, cyc);
      end else begin
        ent = exp_q.pop_front();
        check("done_dut",   32'(id), {30'd0, ent[31:30]});
        check("done_cycle", 32'(cyc), {10'd0, ent[29:8]});
        check("done_rdata", {24'd0, rdat}, {24'd0, ent[7:0]});
      end
    end
  endtask

  // Samples every DUT mid-cycle and drives the pad input: the read value only
  // while the model says the data strobe is low, its complement otherwise.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check_dut(0, {b0.cs_n, b0.rd_n, b0.wr_n, b0.a_d, b0.ad_oe, b0.busy, b0.done}, b0.ad_out, b0.rdata);
      check_dut(1, {b1.cs_n, b1.rd_n, b1.wr_n, b1.a_d, b1.ad_oe, b1.busy, b1.done}, b1.ad_out, b1.rdata);
      check_dut(2, {b2.cs_n, b2.rd_n, b2.wr_n, b2.a_d, b2.ad_oe, b2.busy, b2.done}, b2.ad_out, b2.rdata);
    end
    b0.ad_in = (phase_of(0, cyc - last_k[0]) == PH_DPULSE && !cur_wr[0]) ? cur_rval[0] : ~cur_rval[0];
    b1.ad_in = (phase_of(1, cyc - last_k[1]) == PH_DPULSE && !cur_wr[1]) ? cur_rval[1] : ~cur_rval[1];
    b2.ad_in = (phase_of(2, cyc - last_k[2]) == PH_DPULSE && !cur_wr[2]) ? cur_rval[2] : ~cur_rval[2];
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int id;
    int n;
    ts = '{2, 1, 1};
    tp = '{8, 1, clampi(0)};
    tg = '{4, 1, 1};
    th = '{2, 1, 1};
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 8'h00, 8'h00);
    b0.ad_in = 8'h00;
    b1.ad_in = 8'h00;
    b2.ad_in = 8'h00;

    // Reset values on every instance.
    #23;
    check_rst("reset_dut0", {b0.cs_n, b0.rd_n, b0.wr_n, b0.a_d, b0.ad_oe, b0.busy, b0.done}, b0.ad_out, b0.rdata);
    check_rst("reset_dut1", {b1.cs_n, b1.rd_n, b1.wr_n, b1.a_d, b1.ad_oe, b1.busy, b1.done}, b1.ad_out, b1.rdata);
    check_rst("reset_dut2", {b2.cs_n, b2.rd_n, b2.wr_n, b2.a_d, b2.ad_oe, b2.busy, b2.done}, b2.ad_out, b2.rdata);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Default write, then default read.
    do_start(0, 1'b1, 8'h21, 8'h45, 8'h00);
    wait_cyc(last_k[0] + n_of(0) + 1);
    do_start(0, 1'b0, 8'h02, 8'h00, 8'h37);
    wait_cyc(last_k[0] + n_of(0) + 3);

    // Starts while busy and while in DONE are dropped.
    do_start(0, 1'b1, 8'h33, 8'h66, 8'h00);
    k = last_k[0];
    n = n_of(0);
    wait_cyc(k + 4);
    do_start(0, 1'b0, 8'hAA, 8'hBB, 8'hCC);
    wait_cyc(k + n);
    do_start(0, 1'b0, 8'hAA, 8'hBB, 8'hCC);
    wait_cyc(k + n + 4);

    // Asynchronous reset in the 4th data-strobe cycle of a read.
    do_start(0, 1'b0, 8'h5A, 8'h00, 8'hC3);
    k = last_k[0];
    wait_cyc(k + ts[0] + tp[0] + tg[0] + 3);
    #2;
    reset = 1'b1;
    #1;
    check_rst("midreset_dut0", {b0.cs_n, b0.rd_n, b0.wr_n, b0.a_d, b0.ad_oe, b0.busy, b0.done}, b0.ad_out, b0.rdata);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_start(0, 1'b0, 8'h11, 8'h00, 8'h9E);
    wait_cyc(last_k[0] + n_of(0) + 2);

    // Minimum-length phases, with and without a zero pulse parameter.
    for (int d = 1; d < 3; d++) begin
      do_start(d, 1'b1, 8'h40, 8'h7F, 8'h00);
      wait_cyc(last_k[d] + n_of(d) + 1);
      do_start(d, 1'b0, 8'h41, 8'h00, 8'hD2);
      wait_cyc(last_k[d] + n_of(d) + 2);
    end

    // Back-to-back write then read, start in the cycle after done.
    do_start(0, 1'b1, 8'h07, 8'hE1, 8'h00);
    wait_cyc(last_k[0] + n_of(0) + 1);
    do_start(0, 1'b0, 8'h08, 8'h00, 8'h5B);
    wait_cyc(last_k[0] + n_of(0) + 1);

    // Randomized transactions with occasional stray starts.
    for (int i = 0; i < 24; i++) begin
      id = (i % 3 == 2) ? 1 : 0;
      do_start(id, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
      k = last_k[id];
      n = n_of(id);
      if ($urandom_range(0, 1) == 1) begin
        wait_cyc(k + $urandom_range(0, n));
        do_start(id, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      wait_cyc(k + n + 1 + $urandom_range(0, 3));
    end

    // Every accepted transaction must have produced its done.
    wait_cyc(cyc + 40);
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL missing_done: got %0d outstanding expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
